// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the planned receiver.
//   uart_state_t : frame FSM state encoding
//   PAR_*        : values of the PARITY parameter
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts baud ticks and flags the tick that ends a bit.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : synchronous clear of the tick counter (has priority over tick)
//   tick       : one-clk baud pulse, OVERSAMPLE pulses per bit
//   bit_end    : high during the tick that completes the current bit period
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic bit_end
);

   localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

   logic [CNT_W-1:0] tick_cnt;

   // A tick arriving together with clear is discarded, so it cannot end a bit.
   assign bit_end = tick && !clear && (tick_cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (clear) begin
         tick_cnt <= '0;
      end else if (tick) begin
         if (tick_cnt == LAST) tick_cnt <= '0;
         else                  tick_cnt <= tick_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, STOP_BITS stop bits. Words are taken through a
// valid/ready handshake and registered at acceptance.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   br_tick    : one-clk baud pulse, OVERSAMPLE pulses per bit
//   i_valid    : source presents i_data
//   i_data     : word to send
//   o_ready    : transmitter idle and able to accept a word
//   o_busy     : frame in progress
//   o_done     : one-clk pulse when the last stop bit ends
//   tx         : serial line, idle high, registered
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 br_tick,
   input  logic                 i_valid,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_ready,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 tx
);

   if (DATA_BITS < 5 || DATA_BITS > 9 ||
       (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) ||
       (STOP_BITS != 1 && STOP_BITS != 2) ||
       OVERSAMPLE < 1 || OVERSAMPLE > 64) begin : g_param_check
      $error("uart_tx_cfg: parameter out of range (DATA_BITS=%0d PARITY=%0d STOP_BITS=%0d OVERSAMPLE=%0d)",
             DATA_BITS, PARITY, STOP_BITS, OVERSAMPLE);
   end

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   uart_state_t          state;
   logic [DATA_BITS-1:0] shreg;
   logic [3:0]           bit_cnt;
   logic                 par_bit;
   logic                 bit_end;
   logic                 timer_clear;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return (PARITY == PAR_ODD) ? ~^d : ^d;
   endfunction

   assign o_ready = (state == ST_IDLE);

   // Holding the timer clear while idle guarantees every frame starts from a
   // zero count, and drops a br_tick that lands on the accept edge.
   assign timer_clear = (state == ST_IDLE);

   uart_bit_timer #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_bit_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .tick    (br_tick),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         tx      <= 1'b1;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         shreg   <= '0;
         bit_cnt <= '0;
         par_bit <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               tx     <= 1'b1;
               o_busy <= 1'b0;
               if (i_valid) begin
                  shreg   <= i_data;
                  par_bit <= parity_of(i_data);
                  bit_cnt <= '0;
                  tx      <= 1'b0;
                  o_busy  <= 1'b1;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  tx    <= shreg[0];
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  shreg <= shreg >> 1;
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     if (PARITY != PAR_NONE) begin
                        tx    <= par_bit;
                        state <= ST_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     // Next data bit is the one about to become shreg[0].
                     tx      <= shreg[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  tx    <= 1'b1;
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               // bit_cnt is reused here to count stop bits.
               if (bit_end) begin
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= '0;
                     o_busy  <= 1'b0;
                     o_done  <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               tx     <= 1'b1;
               o_busy <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
